// File: rtl/regfile_scoreboard_if.sv
// Bus between decode/writeback and the register file.
// master: decode + writeback side (drives addresses, write port, issue).
// slave : register file (returns read data, pending bits and busy).
// Ports of the bundle:
//   init_req   restart the init sequence (honoured only in RUN)
//   busy       high while the init sequencer owns the file
//   rd_addr    NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data    NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_pending NRD scoreboard bits, one per read port
//   we/wa/wd   writeback port
//   iss_valid/iss_rd  issue of an instruction that writes iss_rd
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = 5
);
  logic                  init_req;
  logic                  busy;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_pending;
  logic                  we;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;

  modport master (
    output init_req, rd_addr, we, wa, wd, iss_valid, iss_rd,
    input  busy, rd_data, rd_pending
  );

  modport slave (
    input  init_req, rd_addr, we, wa, wd, iss_valid, iss_rd,
    output busy, rd_data, rd_pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with init sequencer, optional write-to-read
// bypass and a per-register pending scoreboard for hazard detection.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces INIT with cnt=0 and no pending bits
//   bus    regfile_scoreboard_if.slave (reads, writeback, issue, init_req, busy)
// After reset or init_req the sequencer spends NREGS cycles writing every
// register (SP_IDX gets SP_INIT, the rest 0); reads return 0 meanwhile.
module regfile_scoreboard #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     NREGS   = 32,
  parameter int unsigned     NRD     = 2,
  parameter int unsigned     BYPASS  = 1,
  parameter int unsigned     SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 'h0000_8000
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned     AW      = $clog2(NREGS);
  localparam logic [AW-1:0]   LastIdx = AW'(NREGS - 1);
  localparam logic [AW-1:0]   SpAddr  = AW'(SP_IDX);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [NREGS-1:0]   pending_q, pending_d;
  logic               busy;
  logic               run;

  logic [XLEN-1:0]    mem [NREGS];
  logic [AW-1:0]      raddr [NRD];

  // State register, counter and scoreboard share the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        // cnt wraps back to 0 after the last register since NREGS is 2**AW.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        if (bus.init_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    busy     = (state_q == StInit);
    run      = (state_q == StRun);
    bus.busy = busy;
  end

  // Scoreboard: issue sets, writeback clears, set wins on the same register.
  always_comb begin
    pending_d = pending_q;
    if (run) begin
      if (bus.init_req) begin
        pending_d = '0;
      end else begin
        if (bus.we)        pending_d[bus.wa]     = 1'b0;
        if (bus.iss_valid) pending_d[bus.iss_rd] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Storage: the sequencer owns the write port in INIT, writeback in RUN.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= (cnt_q == SpAddr) ? SP_INIT : '0;
    end else if (bus.we && (bus.wa != '0)) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_raddr
    assign raddr[k] = bus.rd_addr[k*AW +: AW];
  end

  // Combinational read ports. A bypassed write also retires the pending bit
  // unless the same register is being re-issued in this cycle.
  always_comb begin
    bus.rd_data    = '0;
    bus.rd_pending = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!busy && (raddr[k] != '0)) begin
        if ((BYPASS != 0) && bus.we && (bus.wa == raddr[k])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wd;
          bus.rd_pending[k]           = bus.iss_valid && (bus.iss_rd == raddr[k]);
        end else begin
          bus.rd_data[k*XLEN +: XLEN] = mem[raddr[k]];
          bus.rd_pending[k]           = pending_q[raddr[k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned NRD     = 3;
  localparam int unsigned AW      = 5;
  localparam int unsigned SP_IDX  = 2;
  localparam logic [31:0] SP_INIT = 32'h0000_8000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) bus1 ();
  regfile_scoreboard_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) bus0 ();

  // The no-bypass instance sees exactly the same inputs.
  assign bus0.init_req  = bus1.init_req;
  assign bus0.rd_addr   = bus1.rd_addr;
  assign bus0.we        = bus1.we;
  assign bus0.wa        = bus1.wa;
  assign bus0.wd        = bus1.wd;
  assign bus0.iss_valid = bus1.iss_valid;
  assign bus0.iss_rd    = bus1.iss_rd;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
  ) u_byp (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
  ) u_nobyp (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    logic                busy;
    logic [NRD*XLEN-1:0] d1;
    logic [NRD-1:0]      p1;
    logic [NRD*XLEN-1:0] d0;
    logic [NRD-1:0]      p0;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: architectural contents, pending flags, init cycles left.
  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  int          init_left;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_data(int a, bit byp, bit we, int wa, logic [31:0] wd);
    if (init_left > 0 || a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_pbit(int a, bit byp, bit we, int wa, bit iss, int iss_rd);
    if (init_left > 0 || a == 0) return 1'b0;
    if (byp && we && wa == a) return iss && (iss_rd == a);
    return m_pend[a];
  endfunction

  // Drive one cycle, queue the expected outputs, then advance the model one edge.
  task automatic cycle(input bit ir, input bit we, input logic [AW-1:0] wa,
                       input logic [31:0] wd, input bit iss, input logic [AW-1:0] iss_rd,
                       input logic [NRD*AW-1:0] ra);
    exp_t e;
    int   a;
    bus1.init_req  = ir;
    bus1.we        = we;
    bus1.wa        = wa;
    bus1.wd        = wd;
    bus1.iss_valid = iss;
    bus1.iss_rd    = iss_rd;
    bus1.rd_addr   = ra;
    e.busy = (init_left > 0);
    for (int k = 0; k < NRD; k++) begin
      a = int'(ra[k*AW +: AW]);
      e.d1[k*XLEN +: XLEN] = m_data(a, 1'b1, we, int'(wa), wd);
      e.d0[k*XLEN +: XLEN] = m_data(a, 1'b0, we, int'(wa), wd);
      e.p1[k] = m_pbit(a, 1'b1, we, int'(wa), iss, int'(iss_rd));
      e.p0[k] = m_pbit(a, 1'b0, we, int'(wa), iss, int'(iss_rd));
    end
    exp_q.push_back(e);
    if (init_left > 0) begin
      init_left--;
      if (init_left == 0)
        for (int i = 0; i < NREGS; i++) m_regs[i] = (i == SP_IDX) ? SP_INIT : 32'h0;
    end else if (ir) begin
      init_left = NREGS;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (iss && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [NRD*AW-1:0] pack3(int a0, int a1, int a2);
    logic [NRD*AW-1:0] r;
    r[0*AW +: AW] = AW'(a0);
    r[1*AW +: AW] = AW'(a1);
    r[2*AW +: AW] = AW'(a2);
    return r;
  endfunction

  task automatic idle(input logic [NRD*AW-1:0] ra);
    cycle(1'b0, 1'b0, '0, 32'h0, 1'b0, '0, ra);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    init_left = NREGS;
    for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    #2;
    check("reset_busy_byp", 128'(bus1.busy), 128'(1));
    check("reset_busy_nobyp", 128'(bus0.busy), 128'(1));
    check("reset_rd_data", 128'(bus1.rd_data), 128'(0));
    check("reset_rd_pending", 128'(bus1.rd_pending), 128'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts busy cycles; an expired bound leaves n at the bound and fails the check.
  task automatic wait_init(input string name);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus1.busy) break;
      n++;
      idle(pack3(SP_IDX, 5, 0));
    end
    check(name, 128'(n), 128'(NREGS));
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // Monitor: outputs are combinational, so one queued expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy_byp", 128'(bus1.busy), 128'(e.busy));
        check("busy_nobyp", 128'(bus0.busy), 128'(e.busy));
        check("rd_data_byp", 128'(bus1.rd_data), 128'(e.d1));
        check("rd_pending_byp", 128'(bus1.rd_pending), 128'(e.p1));
        check("rd_data_nobyp", 128'(bus0.rd_data), 128'(e.d0));
        check("rd_pending_nobyp", 128'(bus0.rd_pending), 128'(e.p0));
      end
    end
  end

  initial begin
    logic [AW-1:0]     wa, ird;
    logic [NRD*AW-1:0] ra;
    int                sel;
    reset          = 1'b1;
    bus1.init_req  = 1'b0;
    bus1.we        = 1'b0;
    bus1.wa        = '0;
    bus1.wd        = '0;
    bus1.iss_valid = 1'b0;
    bus1.iss_rd    = '0;
    bus1.rd_addr   = '0;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    init_left = NREGS;
    @(negedge clk);
    do_reset();
    wait_init("init_busy_len");
    idle(pack3(2, 5, 0));

    // Same-cycle write and read of x9, then read back.
    cycle(1'b0, 1'b1, 5'd9, 32'h0000_0008, 1'b0, '0, pack3(9, 0, 9));
    idle(pack3(9, 9, 9));

    // x0 stays 0 and never pending.
    cycle(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, pack3(0, 0, 0));
    idle(pack3(0, 0, 0));

    // Scoreboard: issue, retire, then issue+retire on the same edge.
    cycle(1'b0, 1'b0, '0, 32'h0, 1'b1, 5'd7, pack3(7, 0, 0));
    idle(pack3(7, 7, 0));
    cycle(1'b0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, '0, pack3(7, 0, 0));
    idle(pack3(7, 0, 0));
    cycle(1'b0, 1'b1, 5'd7, 32'h0000_0078, 1'b1, 5'd7, pack3(7, 7, 0));
    idle(pack3(7, 0, 0));

    // Duplicate addresses with three ports.
    cycle(1'b0, 1'b1, 5'd31, 32'h1234_5678, 1'b0, '0, pack3(0, 0, 0));
    idle(pack3(2, 2, 31));

    // init_req clears contents and pending bits.
    cycle(1'b0, 1'b1, 5'd4, 32'hCAFE_0004, 1'b1, 5'd4, pack3(4, 0, 0));
    idle(pack3(4, 4, 0));
    cycle(1'b1, 1'b0, '0, 32'h0, 1'b0, '0, pack3(4, 0, 0));
    wait_init("init_req_busy_len");
    idle(pack3(4, 7, 31));

    // Reset in the middle of INIT restarts a full sequence.
    cycle(1'b1, 1'b0, '0, 32'h0, 1'b0, '0, pack3(0, 0, 0));
    for (int i = 0; i < 10; i++) idle(pack3(2, 3, 4));
    do_reset();
    wait_init("reset_mid_init_len");
    idle(pack3(2, 4, 7));

    // Randomized traffic, biased toward collisions.
    for (int i = 0; i < 3000; i++) begin
      wa  = rnd_addr();
      ird = rnd_addr();
      for (int k = 0; k < NRD; k++) begin
        sel = int'($urandom_range(0, 3));
        ra[k*AW +: AW] = (sel == 0) ? wa : (sel == 1) ? ird : rnd_addr();
      end
      cycle($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 1)), ird, ra);
    end

    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the pipelined RV32 core, succeeding the fixed 2-read/1-write file.
- Configurable read-port count and width; hardware init sequencer that clears all registers and preloads the stack pointer; optional write-to-read bypass; per-register pending scoreboard for hazard detection.
- Sits between decode (reads, issue) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, at least 4); AW = clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- SP_IDX, 2, register preloaded by the init sequencer.
- SP_INIT, 32'h00008000, value written to SP_IDX during init; all other registers get 0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- init_req  input  1  pulse in RUN; restarts the init sequence.
- busy  output  1  high while in INIT.
- rd_addr  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  output  NRD*XLEN  packed read data, combinational.
- rd_pending  output  NRD  scoreboard bit for each read address, combinational.
- we  input  1  writeback enable.
- wa  input  AW  writeback address.
- wd  input  XLEN  writeback data.
- iss_valid  input  1  issue of an instruction with a destination register.
- iss_rd  input  AW  destination register to mark pending.

Behaviour:
- Reset is asynchronous. It forces state INIT, cnt=0, all pending bits 0 and busy=1. rd_data and rd_pending read 0 while busy.
- States and transitions:
  - INIT -> RUN when cnt == NREGS-1 has been written.
  - RUN -> INIT on init_req.
- INIT:
  - Each cycle writes reg[cnt] <= (cnt==SP_IDX ? SP_INIT : 0), then cnt increments.
  - Takes exactly NREGS cycles. busy falls on the edge after the last write.
  - we, iss_valid and init_req are ignored during INIT.
- RUN entry from init_req: cnt=0, pending cleared on the same edge, busy=1 from the next cycle.
- Write: on a rising edge in RUN with we=1 and wa!=0, reg[wa] <= wd. Writes to x0 are dropped. x0 always reads 0.
- Read, rd_data[k]:
  - 0 if busy or rd_addr[k]==0.
  - Otherwise, if BYPASS=1 and we and wa==rd_addr[k], returns wd.
  - Otherwise returns reg[rd_addr[k]].
  - With BYPASS=0, new data is visible the cycle after the write edge.
- Scoreboard, per-register pending bit, x0 bit hard-wired 0:
  - Edge in RUN: iss_valid sets pending[iss_rd]; we clears pending[wa].
  - Same register set and cleared on one edge: set wins (the newer instruction owns it).
  - Different registers: both updates apply.
- rd_pending[k]:
  - Equals pending[rd_addr[k]].
  - If BYPASS=1 and a same-cycle write to that address occurs, reports 0, unless iss_valid with iss_rd equal to that address is also present.
- Duplicate read addresses across ports return identical data and pending bits.
- No output is registered beyond the storage, pending, cnt and state flops. Read latency is 0 cycles; write latency is 1 edge.

Test Plan:
1. Reset pulse, NREGS=32, then no stimulus -> busy=1 for exactly 32 cycles after reset release. After that, reading x2 gives 32'h00008000 and reading x5 gives 0.
2. RUN; we=1, wa=9, wd=32'h0000_0008 with rd_addr0=9 in the same cycle:
   - BYPASS=1 -> rd_data0 = 8 in that cycle.
   - BYPASS=0 -> old value (0) in that cycle, 8 the next cycle.
3. we=1, wa=0, wd=32'hDEADBEEF -> reading x0 gives 0 on all ports. iss_valid with iss_rd=0 -> rd_pending stays 0.
4. Scoreboard sequence:
   - iss_valid, iss_rd=7 -> rd_pending for x7 = 1 the next cycle.
   - we with wa=7, no issue -> pending clears after that edge.
   - iss_valid, iss_rd=7 together with we, wa=7 -> pending stays 1.
5. NRD=3 with addresses {2,2,31} after init, and x31 written to 32'h12345678 -> outputs 32'h00008000, 32'h00008000, 32'h12345678.
6. Registers loaded and x4 pending; init_req asserted -> all pending bits 0 and x4 reads 0 after 32 busy cycles. Asserting reset midway through INIT restarts cnt at 0 and gives a full 32-cycle busy.
